uart_transmit: RTL and testbench

- UART transmitter: serialises bytes onto a single TX wire as 8N1 frames (1 start, 8 data LSB-first, 1 stop). Default rate is MIDI 31250 baud.
- Fabric-side logic (MIDI out, debug/log path) pushes bytes through a valid/ready handshake into a small internal FIFO, so bursts can be queued.
- It is the transmit counterpart of uart_receive and must loop back cleanly into it.

---
 rtl/uart_transmit.sv | 167 ++++++++++++++++
 tb/tb_uart_transmit.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter behind a small byte FIFO. Byte into an idle, empty unit: start bit 1 cycle after accept.
// Backpressure: ready drops only while the FIFO holds FIFO_DEPTH bytes; a pop never frees a slot in the same cycle.

module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    output logic                         push_rdy,
    input  logic                         pop_rdy,
    output logic                         pop_vld,
    output logic [WIDTH-1:0]             pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // Fullness comes from the registered count only, so a full FIFO cannot refill on its pop cycle.
    assign push_rdy = rst_n && (count_q < CW'(DEPTH));
    assign pop_vld  = (count_q != '0);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;
    assign pop_dat  = mem[rd_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module uart_transmit #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 31250,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              data_valid_in,
    input  logic [7:0]                        data_byte_in,
    output logic                              ready_out,
    output logic                              tx_wire_out,
    output logic                              busy_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_out
);
    localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int PW = (BAUD_BIT_PERIOD > 1) ? $clog2(BAUD_BIT_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [PW-1:0] baud_q, baud_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        tx_q, tx_d;
    logic        pop, have_byte, period_end;
    logic [7:0]  head_dat;

    fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .push_vld (data_valid_in),
        .push_dat (data_byte_in),
        .push_rdy (ready_out),
        .pop_rdy  (pop),
        .pop_vld  (have_byte),
        .pop_dat  (head_dat),
        .count    (fifo_count_out)
    );

    assign period_end  = (baud_q == PW'(BAUD_BIT_PERIOD - 1));
    assign tx_wire_out = tx_q;
    assign busy_out    = (state_q != IDLE) || have_byte;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (have_byte) state_d = START;
            START: if (period_end) state_d = DATA;
            DATA:  if (period_end && idx_q == 3'd7) state_d = STOP;
            STOP:  if (period_end) state_d = have_byte ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        tx_d    = tx_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        baud_d  = period_end ? '0 : baud_q + PW'(1);
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (have_byte) begin
                    pop     = 1'b1;
                    shift_d = head_dat;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (period_end) begin
                    tx_d  = shift_q[0];
                    idx_d = 3'd0;
                end
            end
            DATA: begin
                if (period_end) begin
                    if (idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Chaining straight into the next start bit keeps back-to-back frames gapless.
                if (period_end && have_byte) begin
                    pop     = 1'b1;
                    shift_d = head_dat;
                    tx_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit at P=10: timeline reference model, per-cycle scoreboard and a line receiver.
module tb_uart_transmit;
    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 4;
    localparam int P      = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * P;
    localparam int CW     = $clog2(DEPTH + 1);

    logic          clk_in;
    logic          rst_n_in;
    logic          data_valid_in;
    logic [7:0]    data_byte_in;
    logic          ready_out;
    logic          tx_wire_out;
    logic          busy_out;
    logic [CW-1:0] fifo_count_out;

    uart_transmit #(
        .INPUT_CLOCK_FREQ (CLK_HZ),
        .BAUD_RATE        (BAUD),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .data_valid_in  (data_valid_in),
        .data_byte_in   (data_byte_in),
        .ready_out      (ready_out),
        .tx_wire_out    (tx_wire_out),
        .busy_out       (busy_out),
        .fifo_count_out (fifo_count_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit sb_en  = 1'b0;

    // Reference model: accept edge, frame start edge and byte of every accepted byte since reset.
    int         a_q[$];
    int         s_q[$];
    logic [7:0] b_q[$];
    logic [7:0] exp_q[$];
    int         m_last_s = -1000000;

    function automatic void m_clear();
        a_q.delete();
        s_q.delete();
        b_q.delete();
        m_last_s = -1000000;
    endfunction

    function automatic int m_count(int c);
        int n = 0;
        foreach (a_q[i]) if (a_q[i] <= c) n++;
        foreach (s_q[i]) if (s_q[i] <= c) n--;
        return n;
    endfunction

    function automatic bit m_active(int c);
        foreach (s_q[i]) if (c >= s_q[i] && c < s_q[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_tx(int c);
        int k;
        foreach (s_q[i]) begin
            if (c >= s_q[i] && c < s_q[i] + FRAME) begin
                k = (c - s_q[i]) / P;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return b_q[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic bit m_busy(int c);
        return (m_count(c) != 0) || m_active(c);
    endfunction

    // One clock: drive inputs, let the model decide acceptance, return just after the falling edge.
    task automatic step(input logic v, input logic [7:0] b, output bit acc);
        int s;
        data_valid_in = v;
        data_byte_in  = b;
        acc = v && rst_n_in && (m_count(cyc) < DEPTH);
        @(posedge clk_in);
        cyc++;
        if (acc) begin
            s = (cyc + 1 > m_last_s + FRAME) ? cyc + 1 : m_last_s + FRAME;
            a_q.push_back(cyc);
            s_q.push_back(s);
            b_q.push_back(b);
            exp_q.push_back(b);
            m_last_s = s;
        end
        @(negedge clk_in);
        #1;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (busy_out === 1'b1 && n < 3000) begin
            step(1'b0, 8'h00, acc);
            n++;
        end
        repeat (5) step(1'b0, 8'h00, acc);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout busy_out=%b required 0", busy_out);
        end
    endtask

    always @(negedge clk_in) begin
        logic          e_tx, e_rdy, e_busy;
        logic [CW-1:0] e_cnt;
        if (sb_en) begin
            if (!rst_n_in) begin
                e_tx = 1'b1; e_rdy = 1'b0; e_busy = 1'b0; e_cnt = '0;
            end else begin
                e_tx   = m_tx(cyc);
                e_cnt  = CW'(m_count(cyc));
                e_busy = m_busy(cyc);
                e_rdy  = (m_count(cyc) < DEPTH);
            end
            checks++;
            if ({tx_wire_out, ready_out, busy_out, fifo_count_out} !== {e_tx, e_rdy, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d tx=%b/%b ready=%b/%b busy=%b/%b count=%0d/%0d (got/required)",
                         cyc, tx_wire_out, e_tx, ready_out, e_rdy, busy_out, e_busy, fifo_count_out, e_cnt);
            end
        end
    end

    // Behavioural line receiver: samples mid-bit, stop bit must be high.
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh;
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;

    always @(negedge clk_in) begin
        int k;
        if (!rst_n_in) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx_wire_out === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % P == P / 2) begin
                k = rx_cnt / P;
                if (k >= 1 && k <= 8) rx_sh[k-1] = tx_wire_out;
                if (k == 9) begin
                    if (tx_wire_out === 1'b1) rx_q.push_back(rx_sh);
                    else rx_ferr++;
                    rx_act = 1'b0;
                end
            end
        end
    end

    task automatic test_reset();
        bit acc;
        rst_n_in = 1'b0;
        #1;
        checks++; if (tx_wire_out !== 1'b1) begin errors++; $display("FAIL reset_tx got %b required 1", tx_wire_out); end
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b required 0", ready_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy_out); end
        checks++; if (fifo_count_out !== '0) begin errors++; $display("FAIL reset_count got %0d required 0", fifo_count_out); end
        m_clear();
        sb_en = 1'b1;
        repeat (3) step(1'b1, 8'h3C, acc);
        rst_n_in = 1'b1;
        repeat (2) step(1'b0, 8'h00, acc);
    endtask

    task automatic test_idle();
        bit acc;
        int bad = 0;
        repeat (FRAME) begin
            step(1'b0, 8'($urandom), acc);
            if (tx_wire_out !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_line low_cycles=%0d required 0", bad); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL idle_ready got %b required 1", ready_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL idle_busy got %b required 0", busy_out); end
    endtask

    task automatic test_single();
        bit acc;
        int ka = -1, t_fall = -1, t_idle = -1;
        exp_q.delete(); rx_q.delete(); rx_ferr = 0;
        step(1'b1, 8'hA5, acc);
        if (acc) ka = cyc;
        for (int n = 0; n < 300 && t_idle < 0; n++) begin
            step(1'b0, 8'h00, acc);
            if (t_fall < 0 && tx_wire_out === 1'b0) t_fall = cyc;
            else if (t_fall >= 0 && busy_out === 1'b0) t_idle = cyc;
        end
        checks++; if (t_fall !== ka + 1) begin errors++; $display("FAIL single_start_latency fall=%0d required %0d", t_fall, ka + 1); end
        checks++; if (t_idle - t_fall !== FRAME) begin errors++; $display("FAIL single_busy_len got %0d required %0d", t_idle - t_fall, FRAME); end
        checks++; if (rx_q.size() !== 1 || rx_ferr !== 0) begin errors++; $display("FAIL single_rx_count got %0d ferr=%0d required 1", rx_q.size(), rx_ferr); end
        else begin
            checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL single_rx_byte got %h required a5", rx_q[0]); end
        end
    endtask

    task automatic test_burst();
        bit acc;
        int i = 0, ka = -1, t_fall = -1, t_idle = -1;
        drain();
        exp_q.delete(); rx_q.delete(); rx_ferr = 0;
        for (int n = 0; n < 1500 && t_idle < 0; n++) begin
            step(i < 5, 8'(i + 1), acc);
            if (acc) begin
                if (i == 0) ka = cyc;
                i++;
            end
            if (t_fall < 0 && tx_wire_out === 1'b0) t_fall = cyc;
            else if (t_fall >= 0 && i == 5 && busy_out === 1'b0) t_idle = cyc;
        end
        checks++; if (t_fall !== ka + 1) begin errors++; $display("FAIL burst_start fall=%0d required %0d", t_fall, ka + 1); end
        checks++; if (t_idle - t_fall !== 5 * FRAME) begin errors++; $display("FAIL burst_length got %0d required %0d", t_idle - t_fall, 5 * FRAME); end
        checks++; if (rx_q.size() !== 5) begin errors++; $display("FAIL burst_rx_count got %0d required 5", rx_q.size()); end
        else foreach (rx_q[j]) begin
            checks++; if (rx_q[j] !== 8'(j + 1)) begin errors++; $display("FAIL burst_rx_byte%0d got %h required %h", j, rx_q[j], 8'(j + 1)); end
        end
    endtask

    task automatic test_full_contention();
        bit acc;
        int i = 0, s2 = -100, acc6 = -1, n = 0;
        int c_before = -1, c_pop = -1, c_after = -1;
        logic r_before = 1'bx, r_pop = 1'bx;
        drain();
        exp_q.delete(); rx_q.delete(); rx_ferr = 0;
        while (n < 400 && !(i == 6 && cyc > s2 + 1)) begin
            step(i < 6, 8'(8'h61 + i), acc);
            n++;
            if (acc) begin
                if (i == 1) s2 = m_last_s;
                if (i == 5) acc6 = cyc;
                i++;
            end
            if (cyc == s2 - 1) begin c_before = int'(fifo_count_out); r_before = ready_out; end
            if (cyc == s2)     begin c_pop    = int'(fifo_count_out); r_pop    = ready_out; end
            if (cyc == s2 + 1) c_after = int'(fifo_count_out);
        end
        checks++; if (c_before !== 4 || r_before !== 1'b0) begin errors++; $display("FAIL full_pop_cycle count=%0d ready=%b required 4/0", c_before, r_before); end
        checks++; if (c_pop !== 3 || r_pop !== 1'b1) begin errors++; $display("FAIL full_after_pop count=%0d ready=%b required 3/1", c_pop, r_pop); end
        checks++; if (c_after !== 4) begin errors++; $display("FAIL full_refill count=%0d required 4", c_after); end
        checks++; if (acc6 !== s2 + 1) begin errors++; $display("FAIL full_accept_edge got %0d required %0d", acc6, s2 + 1); end
        drain();
        checks++; if (rx_q.size() !== 6 || rx_ferr !== 0) begin errors++; $display("FAIL full_rx_count got %0d ferr=%0d required 6", rx_q.size(), rx_ferr); end
        else foreach (rx_q[j]) begin
            checks++; if (rx_q[j] !== 8'(8'h61 + j)) begin errors++; $display("FAIL full_rx_byte%0d got %h required %h", j, rx_q[j], 8'(8'h61 + j)); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        int i = 0, s0 = -1, n = 0, bad = 0;
        drain();
        while (i < 3 && n < 50) begin
            step(1'b1, 8'($urandom), acc);
            n++;
            if (acc) begin
                if (i == 0) s0 = m_last_s;
                i++;
            end
        end
        n = 0;
        while (cyc < s0 + 4 * P + P / 2 && n < 200) begin
            step(1'b0, 8'h00, acc);
            n++;
        end
        #1 rst_n_in = 1'b0;
        #1;
        checks++; if (tx_wire_out !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b required 1", tx_wire_out); end
        checks++; if (fifo_count_out !== '0) begin errors++; $display("FAIL midrst_count got %0d required 0", fifo_count_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b required 0", busy_out); end
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b required 0", ready_out); end
        m_clear();
        exp_q.delete();
        repeat (2) step(1'b0, 8'h00, acc);
        rst_n_in = 1'b1;
        repeat (3 * P + 5) begin
            step(1'b0, 8'($urandom), acc);
            if (tx_wire_out !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_spurious low_cycles=%0d required 0", bad); end
        checks++; if (busy_out !== 1'b0 || fifo_count_out !== '0) begin errors++; $display("FAIL midrst_after busy=%b count=%0d required 0/0", busy_out, fifo_count_out); end
    endtask

    task automatic test_random();
        bit acc, hold = 1'b0;
        logic [7:0] b = 8'h00;
        int i = 0, n = 0;
        exp_q.delete(); rx_q.delete(); rx_ferr = 0;
        while (i < 30 && n < 20000) begin
            if (!hold) begin
                b = 8'($urandom);
                hold = ($urandom_range(0, 3) != 0);
            end
            step(hold, hold ? b : 8'($urandom), acc);
            n++;
            if (acc) begin
                hold = 1'b0;
                i++;
            end
            if (!hold && $urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(20, 150)) begin
                    step(1'b0, 8'($urandom), acc);
                    n++;
                end
            end
        end
        drain();
        checks++; if (i !== 30) begin errors++; $display("FAIL random_accepted got %0d required 30", i); end
        checks++; if (rx_q.size() !== exp_q.size() || rx_ferr !== 0) begin errors++; $display("FAIL random_rx_count got %0d ferr=%0d required %0d", rx_q.size(), rx_ferr, exp_q.size()); end
        else foreach (rx_q[j]) begin
            checks++; if (rx_q[j] !== exp_q[j]) begin errors++; $display("FAIL random_rx_byte%0d got %h required %h", j, rx_q[j], exp_q[j]); end
        end
    endtask

    task automatic test_loopback();
        bit acc;
        logic [7:0] lb [4] = '{8'h00, 8'hFF, 8'h55, 8'h90};
        int i = 0, n = 0;
        drain();
        exp_q.delete(); rx_q.delete(); rx_ferr = 0;
        while (i < 4 && n < 100) begin
            step(1'b1, lb[i], acc);
            n++;
            if (acc) i++;
        end
        drain();
        checks++; if (rx_q.size() !== 4 || rx_ferr !== 0) begin errors++; $display("FAIL loop_rx_count got %0d ferr=%0d required 4", rx_q.size(), rx_ferr); end
        else foreach (rx_q[j]) begin
            checks++; if (rx_q[j] !== lb[j]) begin errors++; $display("FAIL loop_rx_byte%0d got %h required %h", j, rx_q[j], lb[j]); end
        end
    endtask

    initial begin
        rst_n_in      = 1'b1;
        data_valid_in = 1'b0;
        data_byte_in  = 8'h00;
        #1;
        test_reset();
        test_idle();
        test_single();
        test_burst();
        test_full_contention();
        test_reset_mid_frame();
        test_random();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d simulation did not complete", cyc);
        $fatal(1, "watchdog");
    end
endmodule
